// File: rtl/cdb_arbiter.sv
// Completion-side arbiter: per-FU result queues drained round-robin onto a
// registered common data bus broadcast, with per-FU backpressure.
module cdb_arbiter #(
  parameter int NUM_FU = 3,
  parameter int DEPTH  = 2,
  parameter int TAG_W  = 5,
  localparam int ID_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [NUM_FU-1:0]       fu_valid,
  input  logic [NUM_FU*32-1:0]    fu_value,
  input  logic [NUM_FU*TAG_W-1:0] fu_tag,
  output logic [NUM_FU-1:0]       fu_ready,
  output logic                    cdb_valid,
  output logic [31:0]             cdb_value,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [ID_W-1:0]         cdb_fu_id
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] head_q  [NUM_FU];
  logic [PTR_W-1:0] head_d  [NUM_FU];
  logic [PTR_W-1:0] tail_q  [NUM_FU];
  logic [PTR_W-1:0] tail_d  [NUM_FU];
  logic [CNT_W-1:0] count_q [NUM_FU];
  logic [CNT_W-1:0] count_d [NUM_FU];

  logic [31:0]      valMem_q [NUM_FU][DEPTH];
  logic [TAG_W-1:0] tagMem_q [NUM_FU][DEPTH];

  logic [ID_W-1:0]   rrPtr_q;
  logic [ID_W-1:0]   rrPtr_d;
  logic [NUM_FU-1:0] req;
  logic [NUM_FU-1:0] reqRot;
  logic [NUM_FU-1:0] enqEn;
  logic [NUM_FU-1:0] deqEn;
  logic              grantValid;
  logic [ID_W-1:0]   grantId;
  int                winnerSum;

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      req[i]      = (count_q[i] != '0);
      fu_ready[i] = (count_q[i] < CNT_W'(DEPTH));
      enqEn[i]    = fu_valid[i] && fu_ready[i] && !flush;
    end
  end

  // Rotate requests so bit 0 is the FU at rrPtr_q; the first set bit wins.
  always_comb begin
    reqRot     = NUM_FU'({req, req} >> rrPtr_q);
    grantValid = 1'b0;
    grantId    = '0;
    winnerSum  = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (!grantValid && reqRot[k]) begin
        grantValid = !flush;
        winnerSum  = int'(rrPtr_q) + k;
        if (winnerSum >= NUM_FU) winnerSum = winnerSum - NUM_FU;
        grantId    = ID_W'(winnerSum);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      deqEn[i]   = grantValid && (grantId == ID_W'(i));
      head_d[i]  = head_q[i];
      tail_d[i]  = tail_q[i];
      count_d[i] = count_q[i];
      if (flush) begin
        head_d[i]  = '0;
        tail_d[i]  = '0;
        count_d[i] = '0;
      end else begin
        if (enqEn[i]) tail_d[i] = ptrInc(tail_q[i]);
        if (deqEn[i]) head_d[i] = ptrInc(head_q[i]);
        if (enqEn[i] && !deqEn[i]) count_d[i] = count_q[i] + 1'b1;
        else if (!enqEn[i] && deqEn[i]) count_d[i] = count_q[i] - 1'b1;
      end
    end
    rrPtr_d = rrPtr_q;
    if (flush) rrPtr_d = '0;
    else if (grantValid) rrPtr_d = (grantId == ID_W'(NUM_FU - 1)) ? '0 : grantId + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
      rrPtr_q <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        head_q[i]  <= head_d[i];
        tail_q[i]  <= tail_d[i];
        count_q[i] <= count_d[i];
      end
      rrPtr_q <= rrPtr_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (enqEn[i]) begin
        valMem_q[i][tail_q[i]] <= fu_value[32*i +: 32];
        tagMem_q[i][tail_q[i]] <= fu_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  // Broadcast data holds its last value when nothing is granted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cdb_valid <= 1'b0;
      cdb_value <= '0;
      cdb_tag   <= '0;
      cdb_fu_id <= '0;
    end else if (grantValid) begin
      cdb_valid <= 1'b1;
      cdb_value <= valMem_q[grantId][head_q[grantId]];
      cdb_tag   <= tagMem_q[grantId][head_q[grantId]];
      cdb_fu_id <= grantId;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed table-driven bench for cdb_arbiter (3 FUs, depth 2), plus a
// hand-written asynchronous reset sequence.
module tb_cdb_arbiter;

  logic        clock;
  logic        reset;
  logic        flush;
  logic [2:0]  fu_valid;
  logic [95:0] fu_value;
  logic [14:0] fu_tag;
  logic [2:0]  fu_ready;
  logic        cdb_valid;
  logic [31:0] cdb_value;
  logic [4:0]  cdb_tag;
  logic [1:0]  cdb_fu_id;

  int vecCount  = 0;
  int missCount = 0;

  logic [31:0] lastVal;
  logic [4:0]  lastTag;
  logic [1:0]  lastId;

  typedef struct {
    bit          doRst;
    bit          fl;
    logic [2:0]  valid;
    logic [31:0] val0, val1, val2;
    logic [4:0]  tag0, tag1, tag2;
    logic [2:0]  expReady;
    logic        expValid;
    logic [31:0] expValue;
    logic [4:0]  expTag;
    logic [1:0]  expId;
  } vec_t;

  vec_t vecs[$];

  cdb_arbiter #(.NUM_FU(3), .DEPTH(2), .TAG_W(5)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .fu_valid  (fu_valid),
    .fu_value  (fu_value),
    .fu_tag    (fu_tag),
    .fu_ready  (fu_ready),
    .cdb_valid (cdb_valid),
    .cdb_value (cdb_value),
    .cdb_tag   (cdb_tag),
    .cdb_fu_id (cdb_fu_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(bit r, bit f, logic [2:0] v,
                              logic [31:0] a0, logic [4:0] t0,
                              logic [31:0] a1, logic [4:0] t1,
                              logic [31:0] a2, logic [4:0] t2,
                              logic [2:0] rdy, logic ev, logic [31:0] eval,
                              logic [4:0] etag, logic [1:0] eid);
    vec_t x;
    x.doRst = r;    x.fl = f;       x.valid = v;
    x.val0 = a0;    x.tag0 = t0;
    x.val1 = a1;    x.tag1 = t1;
    x.val2 = a2;    x.tag2 = t2;
    x.expReady = rdy; x.expValid = ev;
    x.expValue = eval; x.expTag = etag; x.expId = eid;
    return x;
  endfunction

  task automatic doReset();
    reset    = 1'b0;
    flush    = 1'b0;
    fu_valid = '0;
    fu_value = '0;
    fu_tag   = '0;
    lastVal  = '0;
    lastTag  = '0;
    lastId   = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t x);
    flush    = x.fl;
    fu_valid = x.valid;
    fu_value = {x.val2, x.val1, x.val0};
    fu_tag   = {x.tag2, x.tag1, x.tag0};
  endtask

  task automatic checkReady(input string what, input logic [2:0] exp);
    vecCount++;
    if (fu_ready !== exp) begin
      missCount++;
      $display("[TB] FAIL %s fu_ready: got %b, want %b", what, fu_ready, exp);
    end
  endtask

  // With no valid broadcast expected, data/tag/id must hold the last broadcast.
  task automatic checkOutput(input string what, input logic expV,
                             input logic [31:0] expVal, input logic [4:0] expTag,
                             input logic [1:0] expId);
    logic [31:0] wv;
    logic [4:0]  wt;
    logic [1:0]  wi;
    wv = expV ? expVal : lastVal;
    wt = expV ? expTag : lastTag;
    wi = expV ? expId  : lastId;
    vecCount++;
    if (cdb_valid !== expV || cdb_value !== wv || cdb_tag !== wt || cdb_fu_id !== wi) begin
      missCount++;
      $display("[TB] FAIL %s cdb: got v=%b val=%h tag=%0d id=%0d, want v=%b val=%h tag=%0d id=%0d",
               what, cdb_valid, cdb_value, cdb_tag, cdb_fu_id, expV, wv, wt, wi);
    end
    if (expV) begin
      lastVal = expVal;
      lastTag = expTag;
      lastId  = expId;
    end
  endtask

  initial begin
    reset    = 1'b0;
    flush    = 1'b0;
    fu_valid = '0;
    fu_value = '0;
    fu_tag   = '0;
    lastVal  = '0;
    lastTag  = '0;
    lastId   = '0;

    // Single result from FU0: broadcast two edges after presentation.
    vecs.push_back(mk(1,0,3'b001, 32'h8,3, 0,0, 0,0, 3'b111, 0,0,0,0));
    vecs.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 1,32'h8,3,0));
    vecs.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 0,0,0,0));
    vecs.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 0,0,0,0));
    // Three-way contention, then FU1/FU2 follow-up starting from rr_ptr = 0.
    vecs.push_back(mk(1,0,3'b111, 32'h11,1, 32'h22,2, 32'h33,3, 3'b111, 0,0,0,0));
    vecs.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 1,32'h11,1,0));
    vecs.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 1,32'h22,2,1));
    vecs.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 1,32'h33,3,2));
    vecs.push_back(mk(0,0,3'b110, 0,0, 32'h44,4, 32'h55,5, 3'b111, 0,0,0,0));
    vecs.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 1,32'h44,4,1));
    vecs.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 1,32'h55,5,2));
    vecs.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 0,0,0,0));
    // FU0 streams values 1..6; its pointers wrap and it never stalls.
    vecs.push_back(mk(0,0,3'b001, 32'd1,6,  0,0, 0,0, 3'b111, 0,0,0,0));
    vecs.push_back(mk(0,0,3'b001, 32'd2,7,  0,0, 0,0, 3'b111, 1,32'd1,6,0));
    vecs.push_back(mk(0,0,3'b001, 32'd3,8,  0,0, 0,0, 3'b111, 1,32'd2,7,0));
    vecs.push_back(mk(0,0,3'b001, 32'd4,9,  0,0, 0,0, 3'b111, 1,32'd3,8,0));
    vecs.push_back(mk(0,0,3'b001, 32'd5,10, 0,0, 0,0, 3'b111, 1,32'd4,9,0));
    vecs.push_back(mk(0,0,3'b001, 32'd6,11, 0,0, 0,0, 3'b111, 1,32'd5,10,0));
    vecs.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 1,32'd6,11,0));
    vecs.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 0,0,0,0));
    // FU2 backpressure while FU0/FU1 hold entries; FU2 holds its result when not ready.
    vecs.push_back(mk(1,0,3'b111, 32'h1014,20, 32'h101E,30, 32'h100A,10, 3'b111, 0,0,0,0));
    vecs.push_back(mk(0,0,3'b111, 32'h1015,21, 32'h101F,31, 32'h100B,11, 3'b111, 1,32'h1014,20,0));
    vecs.push_back(mk(0,0,3'b100, 0,0, 0,0, 32'h100C,12, 3'b001, 1,32'h101E,30,1));
    vecs.push_back(mk(0,0,3'b100, 0,0, 0,0, 32'h100C,12, 3'b011, 1,32'h100A,10,2));
    vecs.push_back(mk(0,0,3'b100, 0,0, 0,0, 32'h100C,12, 3'b111, 1,32'h1015,21,0));
    vecs.push_back(mk(0,0,3'b100, 0,0, 0,0, 32'h100D,13, 3'b011, 1,32'h101F,31,1));
    vecs.push_back(mk(0,0,3'b100, 0,0, 0,0, 32'h100D,13, 3'b011, 1,32'h100B,11,2));
    vecs.push_back(mk(0,0,3'b100, 0,0, 0,0, 32'h100D,13, 3'b111, 1,32'h100C,12,2));
    vecs.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 1,32'h100D,13,2));
    vecs.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 0,0,0,0));
    // Fill queues, flush with fu_valid asserted, then a fresh result afterwards.
    vecs.push_back(mk(1,0,3'b111, 32'hA1,1, 32'hA2,2, 32'hA3,3, 3'b111, 0,0,0,0));
    vecs.push_back(mk(0,0,3'b111, 32'hA4,4, 32'hA5,5, 32'hA6,6, 3'b111, 1,32'hA1,1,0));
    vecs.push_back(mk(0,1,3'b111, 32'hEE,9, 32'hEE,9, 32'hEE,9, 3'b001, 0,0,0,0));
    vecs.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 0,0,0,0));
    vecs.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 0,0,0,0));
    vecs.push_back(mk(0,0,3'b010, 0,0, 32'hB12,12, 0,0, 3'b111, 0,0,0,0));
    vecs.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 1,32'hB12,12,1));
    vecs.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0, 3'b111, 0,0,0,0));

    @(negedge clock);
    for (int r = 0; r < vecs.size(); r++) begin
      if (vecs[r].doRst) doReset();
      applyStimulus(vecs[r]);
      #1;
      checkReady($sformatf("row%0d", r), vecs[r].expReady);
      @(posedge clock);
      #1;
      checkOutput($sformatf("row%0d", r), vecs[r].expValid, vecs[r].expValue,
                  vecs[r].expTag, vecs[r].expId);
      @(negedge clock);
    end

    // Asynchronous reset mid-cycle with FU1/FU2 entries still queued.
    doReset();
    fu_valid = 3'b111;
    fu_value = {32'hC3, 32'hC2, 32'hC1};
    fu_tag   = {5'd3, 5'd2, 5'd1};
    @(posedge clock);
    @(negedge clock);
    fu_valid = '0;
    @(posedge clock);
    #1;
    checkOutput("rst_pre", 1'b1, 32'hC1, 5'd1, 2'd0);
    #2;
    reset   = 1'b0;
    lastVal = '0;
    lastTag = '0;
    lastId  = '0;
    #1;
    checkOutput("rst_async", 1'b0, 32'h0, 5'd0, 2'd0);
    checkReady("rst_async", 3'b111);
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock);
      #1;
      checkOutput($sformatf("rst_post%0d", c), 1'b0, 32'h0, 5'd0, 2'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
